cache_bus_arbiter: RTL and testbench



---
 rtl/cache_bus_arbiter_pkg.sv | 32 +++
 rtl/cache_bus_arbiter_if.sv | 27 ++
 rtl/cache_bus_arbiter_pick.sv | 48 ++++
 rtl/cache_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_cache_bus_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_bus_arbiter_pkg.sv
// Purpose: shared types and constants for the cache-to-bridge arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_bus_arbiter_pkg;

    // Arbiter transaction phase.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    // Which cache owns the bridge port.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // sram-like transfer size encodings.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Starvation counter width; it covers limits 1..15.
    localparam int STARVE_W = 4;

    function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v,
                                                    input logic [STARVE_W-1:0] lim);
        return (v >= lim) ? lim : v + 1'b1;
    endfunction

endpackage

// File: rtl/cache_bus_arbiter_if.sv
// Purpose: one sram-like req/addr_ok/data_ok port carrying a single word.
// Latency: n/a (wiring only).
// Backpressure: req is held by the master until addr_ok; data_ok closes the transfer.
// Ports: req/wr/size/addr/wdata driven by master; rdata/addr_ok/data_ok driven by slave.
interface cache_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              addr_ok;
    logic              data_ok;

    modport master (
        output req, wr, size, addr, wdata,
        input  rdata, addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wdata,
        output rdata, addr_ok, data_ok
    );
endinterface

// File: rtl/cache_bus_arbiter_pick.sv
// Purpose: chooses I or D for the next grant and tracks how long I has been starved.
// Latency: selection is combinational; the starvation count updates on address acceptance.
// Backpressure: none; the caller only samples sel while idle.
// Ports: clk/resetn; i_icache_req/i_dcache_req requests; i_i_acc/i_d_acc accept strobes; o_sel choice.
module cache_arb_pick
    import cache_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter bit D_PRIORITY   = 1'b1
) (
    input  logic   clk,
    input  logic   resetn,
    input  logic   i_icache_req,
    input  logic   i_dcache_req,
    input  logic   i_i_acc,
    input  logic   i_d_acc,
    output owner_t o_sel
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] r_starve_cnt;
    logic                w_starved;

    assign w_starved = (r_starve_cnt == LIMIT);

    // With no request at all the choice rests on D, so the idle mux shows d_*.
    always_comb begin
        o_sel = OWN_D;
        if (i_icache_req && i_dcache_req) begin
            o_sel = (w_starved || !D_PRIORITY) ? OWN_I : OWN_D;
        end else if (i_icache_req) begin
            o_sel = OWN_I;
        end
    end

    // Only D grants made while I is actually waiting count towards starvation.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_starve_cnt <= '0;
        end else if (i_i_acc) begin
            r_starve_cnt <= '0;
        end else if (i_d_acc && i_icache_req) begin
            r_starve_cnt <= sat_inc(r_starve_cnt, LIMIT);
        end
    end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Purpose: shares the single sram-like bridge port between I-cache and D-cache, one transfer in flight.
// Latency: 0-cycle address phase when the bridge accepts at once; data path combinational; 1 bubble after data_ok.
// Backpressure: loser's req is simply left unacknowledged until the winner's data_ok; no preemption.
// Ports: clk, resetn; icache/dcache (slave side of cache ports); bridge (master side toward the AXI bridge).
module cache_bus_arbiter
    import cache_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter bit D_PRIORITY   = 1'b1
) (
    input  logic                 clk,
    input  logic                 resetn,
    cache_bus_arbiter_if.slave   icache,
    cache_bus_arbiter_if.slave   dcache,
    cache_bus_arbiter_if.master  bridge
);

    arb_state_t        r_state;
    owner_t            r_owner;
    owner_t            w_sel;
    owner_t            w_own;
    logic              w_own_req;
    logic              w_req;
    logic              w_acc;
    logic              w_acc_i;
    logic              w_acc_d;
    logic              w_dok;
    logic              w_m_wr;
    logic [1:0]        w_m_size;
    logic [ADDR_W-1:0] w_m_addr;
    logic [DATA_W-1:0] w_m_wdata;
    logic [DATA_W-1:0] w_rdata;

    cache_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .D_PRIORITY   (D_PRIORITY)
    ) u_pick (
        .clk          (clk),
        .resetn       (resetn),
        .i_icache_req (icache.req),
        .i_dcache_req (dcache.req),
        .i_i_acc      (w_acc_i),
        .i_d_acc      (w_acc_d),
        .o_sel        (w_sel)
    );

    // While idle the live selection drives the port; afterwards the locked owner does.
    assign w_own     = (r_state == IDLE) ? w_sel : r_owner;
    assign w_own_req = (w_own == OWN_D) ? dcache.req : icache.req;

    // No request is presented in DATA; resetn gates everything so outputs drop asynchronously.
    assign w_req   = resetn && (r_state != DATA) && w_own_req;
    assign w_acc   = w_req && bridge.addr_ok;
    assign w_acc_i = w_acc && (w_own == OWN_I);
    assign w_acc_d = w_acc && (w_own == OWN_D);
    assign w_dok   = (r_state == DATA) && bridge.data_ok;

    always_comb begin
        w_m_wr    = 1'b0;
        w_m_size  = '0;
        w_m_addr  = '0;
        w_m_wdata = '0;
        if (resetn) begin
            if (w_own == OWN_D) begin
                w_m_wr    = dcache.wr;
                w_m_size  = dcache.size;
                w_m_addr  = dcache.addr;
                w_m_wdata = dcache.wdata;
            end else begin
                w_m_wr    = icache.wr;
                w_m_size  = icache.size;
                w_m_addr  = icache.addr;
                w_m_wdata = icache.wdata;
            end
        end
    end

    assign w_rdata = resetn ? bridge.rdata : '0;

    assign bridge.req   = w_req;
    assign bridge.wr    = w_m_wr;
    assign bridge.size  = w_m_size;
    assign bridge.addr  = w_m_addr;
    assign bridge.wdata = w_m_wdata;

    assign icache.addr_ok = w_acc_i;
    assign dcache.addr_ok = w_acc_d;
    assign icache.data_ok = w_dok && (r_owner == OWN_I);
    assign dcache.data_ok = w_dok && (r_owner == OWN_D);
    assign icache.rdata   = w_rdata;
    assign dcache.rdata   = w_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_owner <= OWN_D;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        r_state <= DATA;
                        r_owner <= w_sel;
                    end else if (w_req) begin
                        r_state <= ADDR;
                        r_owner <= w_sel;
                    end
                end
                ADDR: begin
                    // Owner withdrawing its request aborts the grant without an addr_ok.
                    if (!w_own_req) begin
                        r_state <= IDLE;
                    end else if (bridge.addr_ok) begin
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (bridge.data_ok) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Purpose: self-checking bench for cache_bus_arbiter (vector table, directed sequences, random vs model).
// Latency: n/a.
// Backpressure: n/a.
module tb_cache_bus_arbiter;
    import cache_bus_arbiter_pkg::*;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;
    localparam logic [31:0] I_ADDR = 32'h2000_0100;
    localparam logic [31:0] D_ADDR = 32'h1000_0040;

    logic clk;
    logic resetn;

    cache_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ic();
    cache_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dc();
    cache_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mb();

    cache_bus_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM), .D_PRIORITY(1'b1)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .icache (ic),
        .dcache (dc),
        .bridge (mb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         ireq;
        bit         dreq;
        bit         aok;
        bit         dok;
        logic [4:0] exp_flags;  // {m_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}
        bit         exp_src_d;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {mb.req, ic.addr_ok, dc.addr_ok, ic.data_ok, dc.data_ok};
    endfunction

    task automatic clear_inputs();
        ic.req = 0; ic.wr = 0; ic.size = '0; ic.addr = '0; ic.wdata = '0;
        dc.req = 0; dc.wr = 0; dc.size = '0; dc.addr = '0; dc.wdata = '0;
        mb.addr_ok = 0; mb.data_ok = 0; mb.rdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at posedge+1 with the design idle and inputs cleared.
    task automatic reset_dut();
        clear_inputs();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    // Reference model state: one transaction slot, its owner, and the starvation tally.
    bit busy, addr_done, who_d, who;
    int starve;
    bit r_ireq, r_dreq, r_aok, r_dok, r_iwr, r_dwr, e_mreq, accept, e_dok;
    logic [1:0]  r_isz, r_dsz;
    logic [31:0] r_iaddr, r_daddr, r_iwd, r_dwd, r_rd;
    logic [4:0]  e_flags;
    bit grants[$];
    bit nxt;
    int budget;

    initial begin
        vecs[0]  = '{1, 1, 0, 0, 5'b10000, 1};
        vecs[1]  = '{1, 1, 1, 0, 5'b10100, 1};
        vecs[2]  = '{1, 0, 0, 0, 5'b00000, 0};
        vecs[3]  = '{1, 0, 0, 1, 5'b00001, 0};
        vecs[4]  = '{1, 0, 1, 0, 5'b11000, 0};
        vecs[5]  = '{0, 0, 0, 1, 5'b00010, 0};
        vecs[6]  = '{0, 0, 1, 0, 5'b00000, 0};
        vecs[7]  = '{0, 1, 1, 0, 5'b10100, 1};
        vecs[8]  = '{0, 0, 1, 0, 5'b00000, 0};
        vecs[9]  = '{0, 0, 0, 1, 5'b00001, 0};
        vecs[10] = '{0, 0, 0, 1, 5'b00000, 0};

        // Outputs held at zero during reset even with a live D request.
        clear_inputs();
        resetn = 1'b0;
        dc.req = 1; dc.wr = 1; dc.addr = D_ADDR; dc.wdata = 32'h1234_5678; dc.size = SZ_W;
        mb.addr_ok = 1; mb.rdata = 32'hCAFE_0001;
        #3;
        chk("rst_flags", flags(), 5'b00000);
        chk("rst_maddr", mb.addr, 32'h0);
        chk("rst_mwr", mb.wr, 1'b0);
        chk("rst_mwdata", mb.wdata, 32'h0);
        chk("rst_msize", mb.size, 2'b00);
        chk("rst_drdata", dc.rdata, 32'h0);

        // Vector table.
        reset_dut();
        ic.addr = I_ADDR;
        dc.addr = D_ADDR;
        for (int k = 0; k < 11; k++) begin
            ic.req = vecs[k].ireq;
            dc.req = vecs[k].dreq;
            mb.addr_ok = vecs[k].aok;
            mb.data_ok = vecs[k].dok;
            @(negedge clk);
            chk($sformatf("vec%0d_flags", k), flags(), vecs[k].exp_flags);
            if (vecs[k].exp_flags[4])
                chk($sformatf("vec%0d_maddr", k), mb.addr, vecs[k].exp_src_d ? D_ADDR : I_ADDR);
            next_cycle();
        end

        // D-only read: zero-cycle accept, data_ok three cycles later.
        reset_dut();
        dc.req = 1; dc.addr = D_ADDR; mb.addr_ok = 1;
        @(negedge clk);
        chk("rd_c0_flags", flags(), 5'b10100);
        chk("rd_c0_maddr", mb.addr, D_ADDR);
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            dc.req = 0; mb.addr_ok = 0;
            mb.data_ok = (c == 3);
            mb.rdata = (c == 3) ? 32'hDEAD_BEEF : 32'h0;
            @(negedge clk);
            chk($sformatf("rd_c%0d_flags", c), flags(), (c == 3) ? 5'b00001 : 5'b00000);
        end
        chk("rd_drdata", dc.rdata, 32'hDEAD_BEEF);
        next_cycle();
        clear_inputs();

        // Starvation: both held, bridge accepts at once and completes next cycle.
        reset_dut();
        ic.req = 1; dc.req = 1; ic.addr = I_ADDR; dc.addr = D_ADDR; mb.addr_ok = 1;
        budget = 0;
        grants.delete();
        while (grants.size() < 6 && budget < 100) begin
            @(negedge clk);
            if (dc.addr_ok) grants.push_back(1'b1);
            else if (ic.addr_ok) grants.push_back(1'b0);
            nxt = dc.addr_ok | ic.addr_ok;
            next_cycle();
            mb.data_ok = nxt;
            budget++;
        end
        chk("starve_grant_count", grants.size(), 6);
        for (int g = 0; g < 6; g++)
            if (g < grants.size())
                chk($sformatf("starve_grant%0d_is_d", g), grants[g], (g == 4) ? 1'b0 : 1'b1);
        clear_inputs();

        // Write forwarding, held in ADDR, then owner aborts and pending I wins next cycle.
        reset_dut();
        dc.req = 1; dc.wr = 1; dc.size = SZ_B; dc.addr = 32'h0000_0103; dc.wdata = 32'h0000_00AB;
        @(negedge clk);
        chk("wr_flags", flags(), 5'b10000);
        chk("wr_mwr", mb.wr, 1'b1);
        chk("wr_msize", mb.size, 2'b00);
        chk("wr_maddr", mb.addr, 32'h0000_0103);
        chk("wr_mwdata", mb.wdata, 32'h0000_00AB);
        next_cycle();
        ic.req = 1; ic.addr = I_ADDR;
        @(negedge clk);
        chk("addr_hold_flags", flags(), 5'b10000);
        chk("addr_hold_maddr", mb.addr, 32'h0000_0103);
        next_cycle();
        dc.req = 0; mb.addr_ok = 1;
        @(negedge clk);
        chk("abort_flags", flags(), 5'b00000);
        next_cycle();
        @(negedge clk);
        chk("abort_regrant_flags", flags(), 5'b11000);
        chk("abort_regrant_maddr", mb.addr, I_ADDR);
        next_cycle();
        ic.req = 0; mb.addr_ok = 0; mb.data_ok = 1; mb.rdata = 32'h0BAD_F00D;
        @(negedge clk);
        chk("abort_done_flags", flags(), 5'b00010);
        chk("abort_done_irdata", ic.rdata, 32'h0BAD_F00D);
        next_cycle();
        clear_inputs();

        // Reset pulsed while in DATA.
        reset_dut();
        dc.req = 1; dc.addr = D_ADDR; mb.addr_ok = 1;
        @(negedge clk);
        chk("mid_acc_flags", flags(), 5'b10100);
        next_cycle();
        dc.req = 1; dc.addr = 32'h0000_0055; mb.addr_ok = 1; mb.rdata = 32'h7777_0000;
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_flags", flags(), 5'b00000);
        chk("mid_rst_maddr", mb.addr, 32'h0);
        chk("mid_rst_drdata", dc.rdata, 32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        dc.req = 0; ic.req = 1; ic.addr = I_ADDR; mb.addr_ok = 1;
        @(negedge clk);
        chk("post_rst_flags", flags(), 5'b11000);
        chk("post_rst_maddr", mb.addr, I_ADDR);
        next_cycle();
        ic.req = 0; mb.addr_ok = 0; mb.data_ok = 1; mb.rdata = 32'h0000_1111;
        @(negedge clk);
        chk("post_rst_done_flags", flags(), 5'b00010);
        chk("post_rst_irdata", ic.rdata, 32'h0000_1111);
        next_cycle();

        // Random traffic against the transaction-level model.
        reset_dut();
        busy = 0; addr_done = 0; who_d = 0; starve = 0;
        for (int c = 0; c < 800; c++) begin
            r_ireq  = ($urandom_range(0, 99) < 60);
            r_dreq  = ($urandom_range(0, 99) < 60);
            r_aok   = ($urandom_range(0, 99) < 50);
            r_dok   = ($urandom_range(0, 99) < 40);
            r_iwr   = 1'($urandom_range(0, 1));
            r_dwr   = 1'($urandom_range(0, 1));
            r_isz   = 2'($urandom_range(0, 2));
            r_dsz   = 2'($urandom_range(0, 2));
            r_iaddr = $urandom; r_daddr = $urandom;
            r_iwd   = $urandom; r_dwd   = $urandom; r_rd = $urandom;
            ic.req = r_ireq; ic.wr = r_iwr; ic.size = r_isz; ic.addr = r_iaddr; ic.wdata = r_iwd;
            dc.req = r_dreq; dc.wr = r_dwr; dc.size = r_dsz; dc.addr = r_daddr; dc.wdata = r_dwd;
            mb.addr_ok = r_aok; mb.data_ok = r_dok; mb.rdata = r_rd;
            @(negedge clk);
            if (!busy) begin
                if (r_ireq && r_dreq) who = (starve == LIM) ? 1'b0 : 1'b1;
                else who = r_ireq ? 1'b0 : 1'b1;
                e_mreq = who ? r_dreq : r_ireq;
            end else begin
                who = who_d;
                e_mreq = !addr_done && (who ? r_dreq : r_ireq);
            end
            accept  = e_mreq && r_aok;
            e_dok   = busy && addr_done && r_dok;
            e_flags = {e_mreq, accept && !who, accept && who, e_dok && !who, e_dok && who};
            chk($sformatf("rnd_flags@%0d", c), flags(), e_flags);
            chk($sformatf("rnd_irdata@%0d", c), ic.rdata, r_rd);
            chk($sformatf("rnd_drdata@%0d", c), dc.rdata, r_rd);
            if (e_mreq) begin
                chk($sformatf("rnd_maddr@%0d", c), mb.addr, who ? r_daddr : r_iaddr);
                chk($sformatf("rnd_mwdata@%0d", c), mb.wdata, who ? r_dwd : r_iwd);
                chk($sformatf("rnd_mctl@%0d", c), {mb.wr, mb.size}, who ? {r_dwr, r_dsz} : {r_iwr, r_isz});
            end
            if (accept) begin
                if (!who) starve = 0;
                else if (r_ireq && starve < LIM) starve++;
            end
            if (!busy) begin
                if (e_mreq) begin
                    busy = 1; who_d = who; addr_done = accept;
                end
            end else if (!addr_done) begin
                if (!(who ? r_dreq : r_ireq)) busy = 0;
                else if (r_aok) addr_done = 1;
            end else if (r_dok) begin
                busy = 0; addr_done = 0;
            end
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
